i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified master transmitter with a 16 x 32-bit sample FIFO.
// Generates sck and ws from clk through a programmable prescaler; data changes on sck falling edges.
module i2s_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  sck_prescaler,
  input  logic [4:0]  sample_size,
  input  logic        left_justified,
  input  logic [1:0]  channels,
  input  logic        fifo_wr,
  input  logic [31:0] fifo_wdata,
  input  logic [4:0]  fifo_level_threshold,
  input  logic        underflow_clr,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [4:0]  fifo_level,
  output logic        fifo_level_below,
  output logic        underflow,
  output logic        sck,
  output logic        ws,
  output logic        sdo
);

  // Keep the low N bits of the sample and move them to the top of the shifter (size 0 means 32).
  function automatic logic [31:0] align_sample(input logic [31:0] word, input logic [4:0] size);
    logic [31:0] mask;
    logic [5:0]  shamt;
    if (size == 5'd0) begin
      mask  = 32'hFFFF_FFFF;
      shamt = 6'd0;
    end else begin
      mask  = (32'd1 << size) - 32'd1;
      shamt = 6'd32 - {1'b0, size};
    end
    return (word & mask) << shamt;
  endfunction

  logic [7:0]  prescaler_r;
  logic        sck_r;
  logic        ws_r;
  logic [4:0]  bit_ctr_r;
  logic [31:0] shifter_r;
  logic        sdo_r;
  logic        lj_r;
  logic        underflow_r;
  logic [31:0] mem_r [16];
  logic [3:0]  wr_ptr_r;
  logic [3:0]  rd_ptr_r;
  logic [4:0]  level_r;
  logic        empty_r;
  logic        full_r;

  logic        fall_evt_s;
  logic        slot_start_s;
  logic        ch_en_s;
  logic        push_s;
  logic        pop_s;
  logic        uf_set_s;
  logic        lj_next_s;
  logic [31:0] shifter_next_s;
  logic [4:0]  level_next_s;

  // Event decode, slot-load decision, shifter next value and FIFO level next value.
  always_comb begin
    fall_evt_s     = 1'b0;
    slot_start_s   = 1'b0;
    ch_en_s        = 1'b0;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    uf_set_s       = 1'b0;
    lj_next_s      = lj_r;
    shifter_next_s = shifter_r;
    level_next_s   = level_r;

    fall_evt_s   = en & (prescaler_r == 8'd0) & sck_r;
    slot_start_s = fall_evt_s & (bit_ctr_r == 5'd0);
    // ws_r still holds the outgoing channel, so ws_r=1 means a left slot is starting
    ch_en_s      = ws_r ? channels[1] : channels[0];
    push_s       = fifo_wr & ~full_r;
    pop_s        = slot_start_s & ch_en_s & ~empty_r;
    uf_set_s     = slot_start_s & ch_en_s & empty_r;

    if (slot_start_s) begin
      lj_next_s = left_justified;
      if (pop_s) begin
        shifter_next_s = align_sample(mem_r[rd_ptr_r], sample_size);
      end else begin
        shifter_next_s = 32'd0;
      end
    end else begin
      lj_next_s      = lj_r;
      shifter_next_s = {shifter_r[30:0], 1'b0};
    end

    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + 5'd1;
      2'b01:   level_next_s = level_r - 5'd1;
      default: level_next_s = level_r;
    endcase
  end

  // Prescaler and sck generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_r <= 8'd0;
      sck_r       <= 1'b0;
    end else if (en) begin
      if (prescaler_r == 8'd0) begin
        prescaler_r <= sck_prescaler;
        sck_r       <= ~sck_r;
      end else begin
        prescaler_r <= prescaler_r - 8'd1;
      end
    end
  end

  // Frame timing, shifter and serial output, all advanced on sck falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_r      <= 1'b1;
      bit_ctr_r <= 5'd0;
      shifter_r <= 32'd0;
      sdo_r     <= 1'b0;
      lj_r      <= 1'b0;
    end else if (fall_evt_s) begin
      bit_ctr_r <= bit_ctr_r + 5'd1;
      shifter_r <= shifter_next_s;
      lj_r      <= lj_next_s;
      // I2S mode outputs the bit the shifter held before this edge: a one-sck delay
      sdo_r     <= lj_next_s ? shifter_next_s[31] : shifter_r[31];
      if (slot_start_s) begin
        ws_r <= ~ws_r;
      end
    end
  end

  // FIFO pointers, level and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 4'd0;
      rd_ptr_r <= 4'd0;
      level_r  <= 5'd0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 4'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 4'd1;
      end
      level_r <= level_next_s;
      empty_r <= (level_next_s == 5'd0);
      full_r  <= (level_next_s == 5'd16);
    end
  end

  // FIFO storage; contents are don't-care until written, reset only clears the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fifo_wdata;
    end
  end

  // Sticky underflow flag; a new underflow beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_r <= 1'b0;
    end else if (uf_set_s) begin
      underflow_r <= 1'b1;
    end else if (underflow_clr) begin
      underflow_r <= 1'b0;
    end
  end

  assign fifo_full        = full_r;
  assign fifo_empty       = empty_r;
  assign fifo_level       = level_r;
  assign fifo_level_below = (level_r < fifo_level_threshold);
  assign underflow        = underflow_r;
  assign sck              = sck_r;
  assign ws               = ws_r;
  assign sdo              = sdo_r;

endmodule
